regfile_multiport: RTL

//  Parametrised register file succeeding the fixed 32x32 two-read-port regfile.
//  - Configurable data width, depth and read-port count.
//  - Byte-masked writes and optional write-to-read bypass.
//  - Optional hardwired zero register.
//  - Sequential bulk-clear engine that sweeps every register to zero.
//  - Sits in the CPU decode/writeback stage. Also reused as a scratch array by peripheral blocks.

---
 rtl/regfile_multiport.sv | 134 +++++++++++++
 1 files changed

// File: rtl/regfile_multiport.sv
// Parametrised multi-read-port register file with byte-masked writes, optional
// write-to-read bypass, optional hardwired zero register and a sequential bulk-clear sweep.
module regfile_multiport #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned NUM_RD   = 2,
    parameter bit          BYPASS   = 1'b0,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                       clock,
    input  logic                       ctrl_reset_n,
    input  logic                       ctrl_writeEn,
    input  logic [ADDR_W-1:0]          ctrl_writeReg,
    input  logic [DATA_W/8-1:0]        ctrl_writeMask,
    input  logic [DATA_W-1:0]          data_writeReg,
    input  logic [NUM_RD*ADDR_W-1:0]   ctrl_readReg,
    output logic [NUM_RD*DATA_W-1:0]   data_readReg,
    input  logic                       ctrl_clear,
    output logic                       clear_busy,
    output logic                       clear_done
);

    localparam int unsigned DEPTH  = 1 << ADDR_W;
    localparam int unsigned NBYTES = DATA_W / 8;
    localparam int unsigned IDX_W  = ADDR_W + 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];
    logic [DATA_W-1:0]   mem_d [DEPTH];

    logic                wr_ok_c;
    logic [DATA_W-1:0]   wr_merged_c;
    logic [ADDR_W-1:0]   rd_addr_c [NUM_RD];

    function automatic logic [DATA_W-1:0] merge_bytes(
        input logic [DATA_W-1:0] old_val,
        input logic [DATA_W-1:0] new_val,
        input logic [NBYTES-1:0] mask
    );
        logic [DATA_W-1:0] res;
        res = old_val;
        for (int b = 0; b < NBYTES; b++) begin
            if (mask[b]) begin
                res[b*8 +: 8] = new_val[b*8 +: 8];
            end
        end
        return res;
    endfunction

    // A write is live only in IDLE and never to the hardwired zero register
    always_comb begin
        wr_ok_c     = ctrl_writeEn && (state_q == ST_IDLE) &&
                      !(ZERO_REG && (ctrl_writeReg == '0));
        wr_merged_c = merge_bytes(mem_q[ctrl_writeReg], data_writeReg, ctrl_writeMask);
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        case (state_q)
            ST_IDLE: begin
                if (wr_ok_c) begin
                    mem_d[ctrl_writeReg] = wr_merged_c;
                end
                if (ctrl_clear) begin
                    state_d = ST_SWEEP;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_SWEEP: begin
                mem_d[idx_q[ADDR_W-1:0]] = '0;
                idx_d = idx_q + IDX_W'(1);
                if (idx_q == IDX_W'(DEPTH - 1)) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    // Combinational read ports; zero register wins over bypass
    always_comb begin
        data_readReg = '0;
        for (int p = 0; p < NUM_RD; p++) begin
            rd_addr_c[p] = ctrl_readReg[p*ADDR_W +: ADDR_W];
            if (ZERO_REG && (rd_addr_c[p] == '0)) begin
                data_readReg[p*DATA_W +: DATA_W] = '0;
            end else if (BYPASS && wr_ok_c && (rd_addr_c[p] == ctrl_writeReg)) begin
                data_readReg[p*DATA_W +: DATA_W] = wr_merged_c;
            end else begin
                data_readReg[p*DATA_W +: DATA_W] = mem_q[rd_addr_c[p]];
            end
        end
    end

    assign clear_busy = busy_q;
    assign clear_done = done_q;

endmodule
